// File: rtl/util_pkg.sv
// Shared types for the pulse scheduler: FSM state encoding.
package util_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DELAY = 2'd1,
    PULSE = 2'd2
  } pulse_sched_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: combinational one-hot grant, pointer remembers the
// last winner and advances only when the grant is consumed (en high).
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic                 rst_n,
  input  logic                 clk,
  input  logic [N-1:0]         req,
  input  logic                 en,
  output logic [N-1:0]         gnt,
  output logic [$clog2(N)-1:0] gnt_id
);

  localparam int IW = $clog2(N);

  logic [IW-1:0] last;
  int            idx;

  // Walk offsets from farthest to nearest so the nearest requester after
  // the last winner is the one left standing.
  always_comb begin
    gnt    = '0;
    gnt_id = '0;
    idx    = 0;
    for (int i = N - 1; i >= 0; i--) begin
      idx = (int'(last) + 1 + i) % N;
      if (req[idx]) begin
        gnt      = '0;
        gnt[idx] = 1'b1;
        gnt_id   = IW'(idx);
      end
    end
  end

  // Reset to N-1 so requester 0 has top priority after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last <= IW'(N - 1);
    end else if (en && (|req)) begin
      last <= gnt_id;
    end
  end

endmodule

// File: rtl/pulse_sched.sv
// Shared delayed-pulse generator: one delay and one width counter time-shared
// among NREQ requesters under round-robin arbitration.
module pulse_sched
  import util_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int DW   = 16,
  parameter int WW   = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NREQ-1:0]         req,
  input  logic [NREQ*DW-1:0]      req_dly,
  input  logic [NREQ*WW-1:0]      req_wid,
  input  logic                    abort,
  output logic [NREQ-1:0]         ack,
  output logic [NREQ-1:0]         pulse,
  output logic                    busy,
  output logic [$clog2(NREQ)-1:0] active_id
);

  localparam int IW = $clog2(NREQ);

  // Handshake: req[i] is a level held until the requester sees ack[i]
  // (a one-cycle strobe); a req still high on the return to IDLE is a new job.

  pulse_sched_state_t state, state_nx;
  logic [DW-1:0]      dly_cnt, dly_nx;
  logic [WW-1:0]      wid_cnt, wid_nx, wid_sel;
  logic [IW-1:0]      id_nx;
  logic [NREQ-1:0]    gnt, pulse_nx;
  logic [IW-1:0]      gnt_id;
  logic               grant;

  assign grant = (state == IDLE) && (|req) && !abort;

  rr_arbiter #(.N(NREQ)) u_arb (
    .rst_n  (rst_n),
    .clk    (clk),
    .req    (req),
    .en     (grant),
    .gnt    (gnt),
    .gnt_id (gnt_id)
  );

  assign wid_sel = req_wid[int'(gnt_id)*WW +: WW];

  always_comb begin
    state_nx = state;
    dly_nx   = dly_cnt;
    wid_nx   = wid_cnt;
    id_nx    = active_id;
    case (state)
      IDLE: begin
        if (grant) begin
          state_nx = DELAY;
          id_nx    = gnt_id;
          dly_nx   = req_dly[int'(gnt_id)*DW +: DW];
          wid_nx   = (wid_sel == '0) ? WW'(1) : wid_sel;
        end
      end
      DELAY: begin
        if (abort) begin
          state_nx = IDLE;
          dly_nx   = '0;
          wid_nx   = '0;
        end else if (dly_cnt == '0) begin
          state_nx = PULSE;
        end else begin
          dly_nx = dly_cnt - 1'b1;
        end
      end
      PULSE: begin
        if (abort) begin
          state_nx = IDLE;
          dly_nx   = '0;
          wid_nx   = '0;
        end else begin
          if (wid_cnt != '0) wid_nx = wid_cnt - 1'b1;
          if (wid_cnt <= WW'(1)) state_nx = IDLE;
        end
      end
      default: begin
        state_nx = IDLE;
        dly_nx   = '0;
        wid_nx   = '0;
      end
    endcase
  end

  always_comb begin
    pulse_nx = '0;
    if (state_nx == PULSE) pulse_nx[id_nx] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      dly_cnt   <= '0;
      wid_cnt   <= '0;
      ack       <= '0;
      pulse     <= '0;
      busy      <= 1'b0;
      active_id <= '0;
    end else begin
      state     <= state_nx;
      dly_cnt   <= dly_nx;
      wid_cnt   <= wid_nx;
      ack       <= grant ? gnt : '0;
      pulse     <= pulse_nx;
      busy      <= (state_nx != IDLE);
      active_id <= id_nx;
    end
  end

endmodule

// File: tb/tb_pulse_sched.sv
// Directed bench for pulse_sched: expected ack/pulse events are queued by
// the drivers and consumed by a negedge monitor.
module tb_pulse_sched;

  localparam int NREQ = 4;
  localparam int DW   = 16;
  localparam int WW   = 8;
  localparam int IW   = $clog2(NREQ);
  localparam int EW   = 32 + NREQ;

  logic                 clk;
  logic                 rst_n;
  logic [NREQ-1:0]      req;
  logic [NREQ*DW-1:0]   req_dly;
  logic [NREQ*WW-1:0]   req_wid;
  logic                 abort;
  logic [NREQ-1:0]      ack;
  logic [NREQ-1:0]      pulse;
  logic                 busy;
  logic [IW-1:0]        active_id;

  int unsigned cyc;
  int          checks;
  int          fails;
  logic [EW-1:0] ack_q[$];
  logic [EW-1:0] pulse_q[$];

  pulse_sched #(.NREQ(NREQ), .DW(DW), .WW(WW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .req_dly   (req_dly),
    .req_wid   (req_wid),
    .abort     (abort),
    .ack       (ack),
    .pulse     (pulse),
    .busy      (busy),
    .active_id (active_id)
  );

  // ---------------- clock / reset / cycle count ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard helpers ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [NREQ-1:0] onehot(input int id);
    logic [NREQ-1:0] v;
    v = '0;
    v[id] = 1'b1;
    return v;
  endfunction

  // Queue the ack at grant cycle g and every pulse cycle of the job.
  task automatic exp_job(input int id, input int g, input int d, input int w);
    int wn;
    wn = (w == 0) ? 1 : w;
    ack_q.push_back({32'(g), onehot(id)});
    for (int k = 0; k < wn; k++) pulse_q.push_back({32'(g + 1 + d + k), onehot(id)});
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    logic [EW-1:0] e;
    if (rst_n === 1'b1) begin
      if (ack !== '0) begin
        if (ack_q.size() == 0) check("ack_extra", {32'(cyc), ack}, '0);
        else begin
          e = ack_q.pop_front();
          check("ack", {32'(cyc), ack}, e);
        end
      end
      if (pulse !== '0) begin
        if (pulse_q.size() == 0) check("pulse_extra", {32'(cyc), pulse}, '0);
        else begin
          e = pulse_q.pop_front();
          check("pulse", {32'(cyc), pulse}, e);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_job(input int id, input int d, input int w);
    req_dly[id*DW +: DW] = d[DW-1:0];
    req_wid[id*WW +: WW] = w[WW-1:0];
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (busy !== 1'b0 && n < 400) begin
      tick();
      n++;
    end
    check(name, 64'(busy), 64'(0));
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    check("rst_ack", 64'(ack), 64'(0));
    check("rst_pulse", 64'(pulse), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_active_id", 64'(active_id), 64'(0));
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int g;
    checks  = 0;
    fails   = 0;
    rst_n   = 1'b1;
    req     = '0;
    abort   = 1'b0;
    req_dly = '0;
    req_wid = '0;
    #2;
    do_reset();

    // Single request: id 1, dly 5, wid 3
    g = cyc + 1;
    set_job(1, 5, 3);
    req[1] = 1'b1;
    exp_job(1, g, 5, 3);
    tick();
    check("t1_active_id", 64'(active_id), 64'(1));
    check("t1_busy_g", 64'(busy), 64'(1));
    tick();
    req[1] = 1'b0;
    repeat (7) tick();
    check("t1_busy_last_pulse", 64'(busy), 64'(1));
    tick();
    check("t1_busy_low", 64'(busy), 64'(0));

    // Zero delay and zero width: id 0
    g = cyc + 1;
    set_job(0, 0, 0);
    req[0] = 1'b1;
    exp_job(0, g, 0, 0);
    tick();
    tick();
    req[0] = 1'b0;
    tick();
    check("t2_pulse_one_cycle", 64'(pulse), 64'(0));
    check("t2_busy_low", 64'(busy), 64'(0));

    // All four held from reset: rotation 0,1,2,3,0 every 5 cycles
    do_reset();
    for (int i = 0; i < NREQ; i++) set_job(i, 2, 1);
    g = cyc + 1;
    req = '1;
    exp_job(0, g, 2, 1);
    exp_job(1, g + 5, 2, 1);
    exp_job(2, g + 10, 2, 1);
    exp_job(3, g + 15, 2, 1);
    exp_job(0, g + 20, 2, 1);
    repeat (22) tick();
    req = '0;
    wait_idle("t3_idle");

    // Delay changed while busy has no effect: id 2, dly 10 -> pulse at G+11
    g = cyc + 1;
    set_job(2, 10, 2);
    req[2] = 1'b1;
    exp_job(2, g, 10, 2);
    tick();
    tick();
    req[2] = 1'b0;
    tick();
    tick();
    set_job(2, 1, 2);
    wait_idle("t4_idle");

    // Abort in DELAY; pending req[3] served afterwards
    g = cyc + 1;
    set_job(0, 100, 1);
    req[0] = 1'b1;
    ack_q.push_back({32'(g), onehot(0)});
    tick();
    tick();
    req[0] = 1'b0;
    repeat (4) tick();
    set_job(3, 0, 1);
    req[3] = 1'b1;
    exp_job(3, g + 22, 0, 1);
    repeat (15) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("t5_busy_after_abort", 64'(busy), 64'(0));
    tick();
    tick();
    req[3] = 1'b0;
    wait_idle("t5_idle");

    // Abort together with a fresh request in IDLE: no grant that cycle
    set_job(2, 1, 1);
    req[2] = 1'b1;
    abort  = 1'b1;
    tick();
    abort = 1'b0;
    check("t6_no_ack", 64'(ack), 64'(0));
    check("t6_no_busy", 64'(busy), 64'(0));
    g = cyc + 1;
    exp_job(2, g, 1, 1);
    tick();
    tick();
    req[2] = 1'b0;
    wait_idle("t6_idle");

    // Reset during PULSE: id 1, dly 0, wid 5, reset in the second pulse cycle
    g = cyc + 1;
    set_job(1, 0, 5);
    req[1] = 1'b1;
    ack_q.push_back({32'(g), onehot(1)});
    pulse_q.push_back({32'(g + 1), onehot(1)});
    pulse_q.push_back({32'(g + 2), onehot(1)});
    tick();
    tick();
    req[1] = 1'b0;
    tick();
    #6;
    rst_n = 1'b0;
    #1;
    check("t7_pulse_async", 64'(pulse), 64'(0));
    check("t7_busy_async", 64'(busy), 64'(0));
    check("t7_ack_async", 64'(ack), 64'(0));
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    check("t7_idle_after_reset", 64'(busy), 64'(0));
    check("t7_no_resume", 64'(pulse), 64'(0));

    // Pointer restarts at 0: requests 1 and 2 together -> 1 first, then 2
    g = cyc + 1;
    set_job(1, 0, 1);
    set_job(2, 0, 1);
    req[1] = 1'b1;
    req[2] = 1'b1;
    exp_job(1, g, 0, 1);
    exp_job(2, g + 3, 0, 1);
    tick();
    tick();
    req[1] = 1'b0;
    repeat (3) tick();
    req[2] = 1'b0;
    wait_idle("t8_idle");

    repeat (4) tick();
    check("ack_q_drained", 64'(ack_q.size()), 64'(0));
    check("pulse_q_drained", 64'(pulse_q.size()), 64'(0));

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
